// File: rtl/hex_tx_formatter_pkg.sv
// Shared calculator definitions: formatter FSM encoding, ASCII constants, message lengths.
package hex_tx_formatter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      FINISH = 2'd2
   } fmt_state_t;

   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_LF      = 8'h0A;
   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_LOWER_A = 8'h61;

   localparam logic [3:0] MSG_LEN_DIGITS = 4'd8;
   localparam logic [3:0] MSG_LEN_CRLF   = 4'd10;

   function automatic logic [3:0] last_byte_idx(input bit add_crlf);
      return add_crlf ? (MSG_LEN_CRLF - 4'd1) : (MSG_LEN_DIGITS - 4'd1);
   endfunction

endpackage

// File: rtl/hex_tx_formatter_nibble2ascii.sv
// Converts one 4-bit nibble to its ASCII hex digit.
// Latency: combinational.
// Backpressure: none.
module nibble2ascii
   import hex_tx_formatter_pkg::*;
#(
   parameter bit UPPERCASE = 1'b1
) (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASCII_UPPER_A : ASCII_LOWER_A;

   always_comb begin
      if (nibble < 4'd10) begin
         ascii = ASCII_ZERO + {4'h0, nibble};
      end else begin
         ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/hex_tx_formatter.sv
// Streams a 32-bit divider result to a UART as 8 ASCII hex digits (+ optional CR LF).
// Latency: first byte valid the cycle after alu_done; one byte per cycle when tx_ready stays high.
// Backpressure: tx_data/tx_valid held while tx_ready=0; alu_done while busy is dropped and flagged as overrun.
module hex_tx_formatter
   import hex_tx_formatter_pkg::*;
#(
   parameter bit UPPERCASE = 1'b1,
   parameter bit ADD_CRLF  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] result,
   input  logic        alu_done,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        busy,
   output logic        fmt_done,
   output logic        overrun
);

   localparam logic [3:0] LAST_IDX = last_byte_idx(ADD_CRLF);

   fmt_state_t  state;
   logic [31:0] cap;
   logic [3:0]  byte_idx;
   logic [3:0]  next_idx;
   logic [3:0]  nibble;
   logic [7:0]  digit_ascii;
   logic [7:0]  next_byte;

   // In IDLE the converter looks at the incoming result so the first digit can be
   // registered on the capture edge; otherwise it prepares the byte after the current one.
   always_comb begin
      next_idx = byte_idx + 4'd1;
      if (state == IDLE) begin
         nibble = result[31:28];
      end else begin
         nibble = cap[{~next_idx[2:0], 2'b00} +: 4];
      end

      if (state == IDLE || next_idx < MSG_LEN_DIGITS) begin
         next_byte = digit_ascii;
      end else if (next_idx == MSG_LEN_DIGITS) begin
         next_byte = ASCII_CR;
      end else begin
         next_byte = ASCII_LF;
      end
   end

   nibble2ascii #(
      .UPPERCASE (UPPERCASE)
   ) u_nibble2ascii (
      .nibble (nibble),
      .ascii  (digit_ascii)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cap      <= 32'h0;
         byte_idx <= 4'd0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         fmt_done <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         fmt_done <= 1'b0;
         overrun  <= alu_done && (state != IDLE);
         case (state)
            IDLE: begin
               if (alu_done) begin
                  cap      <= result;
                  byte_idx <= 4'd0;
                  tx_data  <= next_byte;
                  tx_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  byte_idx <= next_idx;
                  if (byte_idx == LAST_IDX) begin
                     tx_valid <= 1'b0;
                     fmt_done <= 1'b1;
                     state    <= FINISH;
                  end else begin
                     tx_data <= next_byte;
                  end
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_hex_tx_formatter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] result;
   logic        alu_done0, alu_done1;
   logic        tx_ready;

   logic [7:0]  tx_data0, tx_data1;
   logic        tx_valid0, tx_valid1;
   logic        busy0, busy1;
   logic        fmt_done0, fmt_done1;
   logic        overrun0, overrun1;

   int errors = 0;
   int checks = 0;
   int ovr0 = 0;
   int ovr1 = 0;

   // {is_fmt_done_marker, byte}
   logic [8:0] q0[$];
   logic [8:0] q1[$];

   logic       held0 = 1'b0, held1 = 1'b0;
   logic [7:0] held_dat0, held_dat1;

   always #5 clk = ~clk;

   hex_tx_formatter dut (
      .clk      (clk),
      .rst      (rst),
      .result   (result),
      .alu_done (alu_done0),
      .tx_ready (tx_ready),
      .tx_data  (tx_data0),
      .tx_valid (tx_valid0),
      .busy     (busy0),
      .fmt_done (fmt_done0),
      .overrun  (overrun0)
   );

   hex_tx_formatter #(
      .UPPERCASE (1'b0),
      .ADD_CRLF  (1'b0)
   ) dut_lc (
      .clk      (clk),
      .rst      (rst),
      .result   (result),
      .alu_done (alu_done1),
      .tx_ready (tx_ready),
      .tx_data  (tx_data1),
      .tx_valid (tx_valid1),
      .busy     (busy1),
      .fmt_done (fmt_done1),
      .overrun  (overrun1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic push_msg(input int which, input logic [79:0] msg, input int n);
      for (int i = 0; i < n; i++) begin
         logic [8:0] e;
         e = {1'b0, msg[79-8*i -: 8]};
         if (which == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (which == 0) q0.push_back(9'h100); else q1.push_back(9'h100);
   endtask

   task automatic mon_byte(input int which, input logic [7:0] dat);
      logic [8:0] e;
      checks++;
      if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
         errors++;
         $display("FAIL byte_dut%0d: got %02h required no byte", which, dat);
      end else begin
         e = (which == 0) ? q0.pop_front() : q1.pop_front();
         if (e[8]) begin
            errors++;
            $display("FAIL byte_dut%0d: got %02h required fmt_done", which, dat);
         end else if (e[7:0] !== dat) begin
            errors++;
            $display("FAIL byte_dut%0d: got %02h required %02h", which, dat, e[7:0]);
         end
      end
   endtask

   task automatic mon_done(input int which);
      checks++;
      if ((which == 0 && (q0.size() == 0 || !q0[0][8])) ||
          (which == 1 && (q1.size() == 0 || !q1[0][8]))) begin
         errors++;
         $display("FAIL fmt_done_dut%0d: got fmt_done required more bytes or idle", which);
      end else begin
         if (which == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         held0 = 1'b0;
         held1 = 1'b0;
      end else begin
         if (held0) check("hold_dut0", {23'h0, tx_valid0, tx_data0}, {23'h0, 1'b1, held_dat0});
         if (held1) check("hold_dut1", {23'h0, tx_valid1, tx_data1}, {23'h0, 1'b1, held_dat1});
         if (tx_valid0 && tx_ready) mon_byte(0, tx_data0);
         if (tx_valid1 && tx_ready) mon_byte(1, tx_data1);
         if (fmt_done0) mon_done(0);
         if (fmt_done1) mon_done(1);
         if (overrun0) ovr0++;
         if (overrun1) ovr1++;
         held0 = tx_valid0 && !tx_ready;
         held1 = tx_valid1 && !tx_ready;
         held_dat0 = tx_data0;
         held_dat1 = tx_data1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int which, input int maxc, input string name);
      int n = 0;
      while (!(which == 0 ? fmt_done0 : fmt_done1) && n < maxc) begin
         tick();
         n++;
      end
      check(name, {31'h0, (which == 0 ? fmt_done0 : fmt_done1)}, 32'h1);
   endtask

   initial begin
      int cnt;
      int n;
      int ovr_base;
      logic saw;
      logic [3:0] bp_pat;

      bp_pat = 4'b1001;
      rst = 1'b0;
      result = 32'h0;
      alu_done0 = 1'b0;
      alu_done1 = 1'b0;
      tx_ready = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_valid", {31'h0, tx_valid0}, 32'h0);
      check("rst_busy", {31'h0, busy0}, 32'h0);
      check("rst_fmt_done", {31'h0, fmt_done0}, 32'h0);
      check("rst_overrun", {31'h0, overrun0}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data0}, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // back-to-back, tx_ready held high
      result = 32'h0003_0007;
      tx_ready = 1'b1;
      alu_done0 = 1'b1;
      push_msg(0, 80'h3030_3033_3030_3037_0D0A, 10);
      tick();
      alu_done0 = 1'b0;
      check("lat1_valid", {31'h0, tx_valid0}, 32'h1);
      check("lat1_data", {24'h0, tx_data0}, 32'h30);
      check("lat1_busy", {31'h0, busy0}, 32'h1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (tx_valid0) cnt++;
         tick();
      end
      check("b2b_valid_cycles", cnt, 10);
      check("b2b_fmt_done", {31'h0, fmt_done0}, 32'h1);
      check("finish_valid", {31'h0, tx_valid0}, 32'h0);
      check("finish_busy", {31'h0, busy0}, 32'h1);
      tick();
      check("idle_busy", {31'h0, busy0}, 32'h0);
      check("idle_fmt_done", {31'h0, fmt_done0}, 32'h0);

      // lower case, no CR/LF
      result = 32'hDEAD_BEEF;
      alu_done1 = 1'b1;
      push_msg(1, {64'h6465_6164_6265_6566, 16'h0}, 8);
      tick();
      alu_done1 = 1'b0;
      wait_done(1, 20, "lc_fmt_done");
      tick();

      // backpressure 1,0,0,1
      result = 32'h1234_ABCD;
      alu_done0 = 1'b1;
      tx_ready = 1'b1;
      push_msg(0, 80'h3132_3334_4142_4344_0D0A, 10);
      tick();
      alu_done0 = 1'b0;
      n = 0;
      while (!fmt_done0 && n < 80) begin
         tx_ready = bp_pat[n % 4];
         tick();
         n++;
      end
      check("bp_fmt_done", {31'h0, fmt_done0}, 32'h1);
      tx_ready = 1'b1;
      tick();

      // overrun during byte 4, then alu_done in FINISH
      ovr_base = ovr0;
      result = 32'h89AB_CDEF;
      alu_done0 = 1'b1;
      push_msg(0, 80'h3839_4142_4344_4546_0D0A, 10);
      tick();
      alu_done0 = 1'b0;
      tick();
      tick();
      tick();
      result = 32'hFFFF_FFFF;
      alu_done0 = 1'b1;
      tick();
      alu_done0 = 1'b0;
      check("ovr_pulse", {31'h0, overrun0}, 32'h1);
      tick();
      check("ovr_single", {31'h0, overrun0}, 32'h0);
      wait_done(0, 20, "ovr_fmt_done");
      result = 32'h5555_5555;
      alu_done0 = 1'b1;
      tick();
      alu_done0 = 1'b0;
      check("finish_ovr", {31'h0, overrun0}, 32'h1);
      check("finish_ignored_busy", {31'h0, busy0}, 32'h0);
      tick();
      check("finish_ignored_valid", {31'h0, tx_valid0}, 32'h0);
      check("ovr_count", ovr0 - ovr_base, 2);

      // reset during byte 5
      result = 32'h0003_0007;
      alu_done0 = 1'b1;
      push_msg(0, 80'h3030_3033_3030_3037_0D0A, 10);
      tick();
      alu_done0 = 1'b0;
      tick();
      tick();
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", {31'h0, tx_valid0}, 32'h0);
      check("midrst_busy", {31'h0, busy0}, 32'h0);
      check("midrst_tx_data", {24'h0, tx_data0}, 32'h0);
      q0.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (fmt_done0 || tx_valid0) saw = 1'b1;
      end
      check("midrst_abandoned", {31'h0, saw}, 32'h0);
      result = 32'h0000_0000;
      alu_done0 = 1'b1;
      push_msg(0, 80'h3030_3030_3030_3030_0D0A, 10);
      tick();
      alu_done0 = 1'b0;
      wait_done(0, 20, "zero_fmt_done");
      tick();
      tick();

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      check("lc_no_overrun", ovr1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hex_tx_formatter.md
HEX_TX_FORMATTER -- requirements
Module: hex_tx_formatter

Interface
REQ-001 SHALL have parameter UPPERCASE, default 1: 1 = hex digits A-F as 0x41-0x46; 0 = a-f as 0x61-0x66.
REQ-002 SHALL have parameter ADD_CRLF, default 1: 1 = append CR (0x0D) and LF (0x0A) after the digits; 0 = digits only.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port result, input, 32: divider output {remainder[15:0], quotient[15:0]}, valid only in the alu_done cycle.
REQ-006 SHALL have port alu_done, input, 1: single-cycle strobe marking result valid.
REQ-007 SHALL have port tx_ready, input, 1: UART transmitter can accept a byte.
REQ-008 SHALL have port tx_data, output, 8: ASCII byte to the transmitter.
REQ-009 SHALL have port tx_valid, output, 1: tx_data is valid.
REQ-010 SHALL have port busy, output, 1: a message is being emitted.
REQ-011 SHALL have port fmt_done, output, 1: one-cycle pulse after the last byte is accepted.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse when alu_done arrives while busy.

Function
REQ-013 SHALL have FSM states IDLE, SEND and FINISH.
- IDLE -> SEND on alu_done.
- SEND -> FINISH when the last byte is transferred.
- FINISH -> IDLE unconditionally after one cycle.
REQ-014 SHALL capture result into an internal 32-bit register on the clock edge where alu_done=1 in IDLE.
REQ-015 SHALL hold the captured value unchanged until the FSM returns to IDLE.
REQ-016 SHALL emit bytes in this order:
- result[31:28] down to result[3:0], most significant nibble first, 8 digits;
- then, if ADD_CRLF=1, 0x0D followed by 0x0A.
- Message length is therefore 10 bytes (ADD_CRLF=1) or 8 bytes (ADD_CRLF=0).
REQ-017 SHALL map each nibble as: 0-9 -> 0x30-0x39; 10-15 -> A-F or a-f according to UPPERCASE.
REQ-018 SHALL assert tx_valid in every SEND cycle and deassert it in IDLE and FINISH.
REQ-019 SHALL transfer a byte only on a cycle where tx_valid=1 and tx_ready=1.
REQ-020 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-021 SHALL increment a 4-bit byte index on each transfer; the index resets to 0 on entry to SEND.
REQ-022 SHALL place the first byte on tx_data with tx_valid=1 in the cycle after the alu_done edge (latency 1).
REQ-023 SHALL sustain one byte per cycle when tx_ready is held high: 10-byte message occupies SEND for exactly 10 cycles.
REQ-024 SHALL drive busy=1 in SEND and FINISH, and busy=0 in IDLE.
REQ-025 SHALL pulse fmt_done for exactly the one FINISH cycle.
REQ-026 SHALL, when alu_done=1 in SEND or FINISH: ignore the new result, leave the current message undisturbed, and pulse overrun in the following cycle.
REQ-027 SHALL ignore alu_done in the FINISH cycle; a new message is accepted only in IDLE.
REQ-028 SHALL leave tx_data unchanged (don't-care, not forced to zero) outside SEND.

Reset
REQ-029 SHALL, on asserting rst, immediately put the FSM in IDLE and clear the byte index, the captured register and tx_data to 0.
REQ-030 SHALL, on asserting rst, immediately drive tx_valid=0, busy=0, fmt_done=0 and overrun=0.
REQ-031 SHALL abandon any message in progress when rst is asserted mid-message, with no further bytes and no fmt_done.
REQ-032 SHALL leave IDLE only on an alu_done seen on a clock edge after rst deasserts.

Structure
REQ-033 SHALL place in the shared calculator package: the FSM state encoding, the ASCII constants CR, LF, '0', 'A' and 'a', and the message-length constants 8 and 10.
REQ-034 SHALL implement nibble-to-ASCII conversion as one combinational sub-module, nibble2ascii, parameterised by UPPERCASE.
REQ-035 SHALL contain no other sub-modules.

Verification
REQ-036 SHALL cover back-to-back transfer: result=0x0003_0007, alu_done pulse, tx_ready=1 -> bytes 30 30 30 33 30 30 30 37 0D 0A on 10 consecutive cycles, then fmt_done for 1 cycle.
REQ-037 SHALL cover lower-case and no CR/LF: UPPERCASE=0, ADD_CRLF=0, result=0xDEAD_BEEF -> bytes 64 65 61 64 62 65 65 66 only.
REQ-038 SHALL cover backpressure: tx_ready toggling 1,0,0,1 pattern -> tx_data held stable through ready=0 cycles, no byte lost or duplicated, fmt_done only after byte 10.
REQ-039 SHALL cover overrun: second alu_done with result=0xFFFF_FFFF during byte 4 -> overrun pulses once and the original message completes unchanged.
REQ-040 SHALL cover reset mid-message: rst during byte 5 -> tx_valid=0 immediately, no fmt_done; a subsequent alu_done with result=0x0000_0000 -> 30×8 0D 0A.
